// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: multi-mode RGB565 VGA test-pattern source.
//   Selects among vertical bars, horizontal bars, checkerboard, scrolling bars
//   and a timed solid colour. Mode changes and animation steps happen only at
//   frame end so a frame is never torn.
// Ports:
//   vga_clk   in   pixel clock
//   rst_n     in   asynchronous active-low reset
//   pix_x     in   current x (>= H_VALID is outside the active area)
//   pix_y     in   current y (>= V_VALID is outside the active area)
//   mode_sel  in   requested pattern, sampled only at frame end
//   pix_data  out  registered RGB565 pixel, 1 cycle after pix_x/pix_y
//   mode_cur  out  pattern in effect for the current frame
//   frame_end out  registered 1-cycle pulse after the last active pixel
module vga_pattern_gen #(
    parameter int unsigned H_VALID          = 640,
    parameter int unsigned V_VALID          = 480,
    parameter int unsigned NUM_BARS         = 10,
    parameter int unsigned CHECK_LOG2       = 5,
    parameter int unsigned SCROLL_STEP      = 4,
    parameter int unsigned FRAMES_PER_COLOR = 60
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic [2:0]  mode_sel,
    output logic [15:0] pix_data,
    output logic [2:0]  mode_cur,
    output logic        frame_end
);

    localparam int unsigned BW    = H_VALID / NUM_BARS;
    localparam int unsigned BH    = V_VALID / NUM_BARS;
    localparam int unsigned CNT_W = (FRAMES_PER_COLOR > 1) ? $clog2(FRAMES_PER_COLOR) : 1;

    typedef enum logic [2:0] {
        MODE_VBAR   = 3'd0,
        MODE_HBAR   = 3'd1,
        MODE_CHECK  = 3'd2,
        MODE_SCROLL = 3'd3,
        MODE_SOLID  = 3'd4,
        MODE_RSV5   = 3'd5,
        MODE_RSV6   = 3'd6,
        MODE_RSV7   = 3'd7
    } mode_e;

    function automatic logic [15:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    palette = 16'hF800;
            4'd1:    palette = 16'hFC00;
            4'd2:    palette = 16'hFFE0;
            4'd3:    palette = 16'h07E0;
            4'd4:    palette = 16'h07FF;
            4'd5:    palette = 16'h001F;
            4'd6:    palette = 16'hF81F;
            4'd7:    palette = 16'h0000;
            4'd8:    palette = 16'hFFFF;
            default: palette = 16'hD69A;
        endcase
    endfunction

    // Remainder pixels past the last full bar clamp onto the last colour.
    function automatic logic [3:0] bar_idx(input logic [10:0] c, input int unsigned w);
        int unsigned q;
        q = 32'(c) / w;
        if (q > NUM_BARS - 1) q = NUM_BARS - 1;
        return 4'(q);
    endfunction

    mode_e              mode_q, mode_d;
    mode_e              sel_m;
    logic [9:0]         off_q, off_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        pix_q, pix_d;
    logic               fe_q;
    logic               fe_cond;
    logic               active;
    logic [10:0]        xs;
    logic [10:0]        off_sum;

    // Pixel path: colour from the mode of the current frame.
    always_comb begin
        active = (32'(pix_x) < H_VALID) && (32'(pix_y) < V_VALID);
        xs     = {1'b0, pix_x} + {1'b0, off_q};
        if (32'(xs) >= H_VALID) xs = xs - 11'(H_VALID);
        pix_d  = '0;
        if (active) begin
            case (mode_q)
                MODE_VBAR:   pix_d = palette(bar_idx({1'b0, pix_x}, BW));
                MODE_HBAR:   pix_d = palette(bar_idx({1'b0, pix_y}, BH));
                MODE_CHECK:  pix_d = (pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2]) ? 16'hFFFF : 16'h0000;
                MODE_SCROLL: pix_d = palette(bar_idx(xs, BW));
                MODE_SOLID:  pix_d = palette(idx_q);
                default:     pix_d = 16'hD69A;
            endcase
        end
    end

    // Frame-synchronous state: entry clears are tested first so they win
    // over the increment of the mode being entered.
    always_comb begin
        fe_cond = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
        sel_m   = mode_e'(mode_sel);
        off_sum = {1'b0, off_q} + 11'(SCROLL_STEP);
        mode_d  = mode_q;
        off_d   = off_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (fe_cond) begin
            mode_d = sel_m;
            if (sel_m == MODE_SCROLL && mode_q != MODE_SCROLL) begin
                off_d = '0;
            end else if (mode_q == MODE_SCROLL) begin
                off_d = (32'(off_sum) >= H_VALID) ? 10'(off_sum - 11'(H_VALID)) : off_sum[9:0];
            end
            if (sel_m == MODE_SOLID && mode_q != MODE_SOLID) begin
                cnt_d = '0;
                idx_d = '0;
            end else if (mode_q == MODE_SOLID) begin
                if (cnt_q == CNT_W'(FRAMES_PER_COLOR - 1)) begin
                    cnt_d = '0;
                    idx_d = (idx_q == 4'(NUM_BARS - 1)) ? 4'd0 : idx_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_VBAR;
            off_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            pix_q  <= '0;
            fe_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            off_q  <= off_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            pix_q  <= pix_d;
            fe_q   <= fe_cond;
        end
    end

    assign pix_data  = pix_q;
    assign mode_cur  = mode_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
module tb_vga_pattern_gen;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pix_x, pix_y;
    logic [2:0]  mode_sel;
    logic [15:0] pix_data, pix7;
    logic [2:0]  mode_cur, mode7;
    logic        frame_end, fe7;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state of the main instance
    int m_mode, m_off, m_idx, m_cnt;
    logic [15:0] pal_tb [10] = '{16'hF800, 16'hFC00, 16'hFFE0, 16'h07E0, 16'h07FF,
                                 16'h001F, 16'hF81F, 16'h0000, 16'hFFFF, 16'hD69A};

    always #5 vga_clk = ~vga_clk;

    vga_pattern_gen #(.FRAMES_PER_COLOR(2)) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .mode_sel(mode_sel), .pix_data(pix_data), .mode_cur(mode_cur), .frame_end(frame_end)
    );

    vga_pattern_gen #(.NUM_BARS(7)) dut7 (
        .vga_clk(vga_clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .mode_sel(mode_sel), .pix_data(pix7), .mode_cur(mode7), .frame_end(fe7)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_pix(input int x, input int y);
        int b, xs;
        if (x >= 640 || y >= 480) return 16'h0000;
        case (m_mode)
            0: begin b = x / 64; if (b > 9) b = 9; return pal_tb[b]; end
            1: begin b = y / 48; if (b > 9) b = 9; return pal_tb[b]; end
            2: return ((((x >> 5) ^ (y >> 5)) & 1) != 0) ? 16'hFFFF : 16'h0000;
            3: begin
                xs = x + m_off;
                if (xs >= 640) xs = xs - 640;
                b = xs / 64; if (b > 9) b = 9;
                return pal_tb[b];
            end
            4: return pal_tb[m_idx];
            default: return 16'hD69A;
        endcase
    endfunction

    task automatic model_frame_end();
        int sel;
        sel = int'(mode_sel);
        if (sel == 3 && m_mode != 3) m_off = 0;
        else if (m_mode == 3) m_off = (m_off + 4) % 640;
        if (sel == 4 && m_mode != 4) begin
            m_cnt = 0; m_idx = 0;
        end else if (m_mode == 4) begin
            if (m_cnt == 1) begin
                m_cnt = 0; m_idx = (m_idx == 9) ? 0 : m_idx + 1;
            end else m_cnt = m_cnt + 1;
        end
        m_mode = sel;
    endtask

    task automatic model_reset();
        m_mode = 0; m_off = 0; m_idx = 0; m_cnt = 0;
    endtask

    // One pixel per clock: model check every cycle, plus a hand value when lit >= 0.
    task automatic step(input int x, input int y, input int lit);
        logic [15:0] e;
        bit fe;
        e  = model_pix(x, y);
        fe = (x == 639 && y == 479);
        pix_x = 10'(x);
        pix_y = 10'(y);
        @(posedge vga_clk);
        if (fe) model_frame_end();
        #1;
        check($sformatf("pix_model(%0d,%0d)", x, y), pix_data, e);
        if (lit >= 0) check($sformatf("pix_hand(%0d,%0d)", x, y), pix_data, 16'(lit));
        check($sformatf("frame_end(%0d,%0d)", x, y), {15'd0, frame_end}, {15'd0, fe});
        check($sformatf("mode_cur(%0d,%0d)", x, y), {13'd0, mode_cur}, 16'(m_mode));
    endtask

    initial begin
        rst_n = 1'b0; mode_sel = 3'd0; pix_x = '0; pix_y = '0;
        model_reset();
        #12;
        check("rst_pix", pix_data, 16'h0000);
        check("rst_mode", {13'd0, mode_cur}, 16'h0000);
        check("rst_fe", {15'd0, frame_end}, 16'h0000);
        check("rst_pix7", pix7, 16'h0000);
        #6 rst_n = 1'b1;

        // vertical bars, default 10 bars
        step(0, 0, 16'hF800);
        step(63, 0, 16'hF800);
        step(64, 0, 16'hFC00);
        step(320, 240, 16'h001F);
        step(639, 0, 16'hD69A);
        step(700, 0, 16'h0000);
        step(0, 500, 16'h0000);
        // 7 bars: BW=91, remainder clamps to last colour
        step(90, 1, -1);   check("bar7_x90", pix7, 16'hF800);
        step(91, 1, -1);   check("bar7_x91", pix7, 16'hFC00);
        step(545, 1, -1);  check("bar7_x545", pix7, 16'h001F);
        step(546, 1, -1);  check("bar7_x546", pix7, 16'hF81F);
        for (int x = 636; x < 640; x++) begin
            step(x, 2, -1);
            check($sformatf("bar7_x%0d", x), pix7, 16'hF81F);
        end
        step(639, 479, 16'hD69A);

        // horizontal bars
        mode_sel = 3'd1;
        step(639, 479, 16'hD69A);
        step(0, 47, 16'hF800);
        step(0, 48, 16'hFC00);
        step(100, 479, 16'hD69A);

        // checkerboard, requested from frame start
        mode_sel = 3'd2;
        step(0, 0, 16'hF800);
        step(639, 479, 16'hD69A);
        step(0, 0, 16'h0000);
        step(32, 0, 16'hFFFF);
        step(32, 32, 16'h0000);

        // scrolling bars
        mode_sel = 3'd3;
        step(639, 479, 16'hFFFF);
        step(60, 0, 16'hF800);
        step(639, 479, -1);
        step(60, 0, 16'hFC00);
        for (int f = 0; f < 158; f++) step(639, 479, -1);
        step(3, 0, 16'hD69A);    // offset 636: xs=639
        step(4, 0, 16'hF800);    // xs wraps to 0
        step(639, 0, 16'hD69A);  // xs=635
        step(639, 479, -1);      // 160th advance: offset back to 0
        step(60, 0, 16'hF800);
        mode_sel = 3'd0;
        step(639, 479, -1);      // offset advances to 4, then held
        step(60, 0, 16'hF800);
        mode_sel = 3'd3;
        step(639, 479, -1);      // re-entry clears offset
        step(60, 0, 16'hF800);

        // timed solid colour, 2 frames per colour
        mode_sel = 3'd4;
        step(639, 479, -1);
        for (int f = 0; f < 20; f++) begin
            step(100, 100, int'(pal_tb[f / 2]));
            step(639, 479, int'(pal_tb[f / 2]));
        end
        step(5, 5, 16'hF800);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pix", pix_data, 16'h0000);
        check("async_rst_mode", {13'd0, mode_cur}, 16'h0000);
        model_reset();
        #2 rst_n = 1'b1;
        step(0, 0, 16'hF800);

        // mid-frame mode_sel toggles are invisible
        mode_sel = 3'd0;
        step(639, 479, -1);
        mode_sel = 3'd5;
        step(10, 10, 16'hF800);
        mode_sel = 3'd0;
        step(20, 10, 16'hF800);
        step(639, 479, 16'hD69A);
        step(30, 10, 16'hF800);
        mode_sel = 3'd5;
        step(30, 10, 16'hF800);
        step(639, 479, 16'hD69A);
        step(30, 10, 16'hD69A);
        step(700, 10, 16'h0000);
        check("mode5", {13'd0, mode_cur}, 16'h0005);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
